multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 30 +++
 rtl/multicycle_control_retire_counter.sv | 21 ++
 rtl/multicycle_control.sv | 151 +++++++++++++++
 tb/tb_multicycle_control.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes
// and the ALU select/class fields driven by the controller.
package multicycle_control_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_EXEC_R   = 4'd6;
    localparam logic [3:0] ST_ALU_WB   = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;
    localparam logic [3:0] ST_TRAP     = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_NOP    = 7'b0000000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b11;

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// 32-bit retired-instruction counter; wraps naturally at 2^32.
module retire_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 32'd0;
        end else if (inc) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore-style strobes per state, with only
// the fetch handshake and branch zero flag gating outputs combinationally.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        pc_src,
    output logic        illegal,
    output logic [31:0] retired,
    output logic [3:0]  state
);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [6:0] opcode_reg;
    logic       illegal_reg;
    logic       retire_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            opcode_reg  <= OP_NOP;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_DECODE) begin
                opcode_reg <= opcode;
            end
            if (state_next == ST_TRAP) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:    if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_R:               state_next = ST_EXEC_R;
                    OP_LOAD, OP_STORE:  state_next = ST_MEM_ADDR;
                    OP_BRANCH:          state_next = ST_BRANCH;
                    OP_NOP:             state_next = ST_FETCH;
                    default:            state_next = ST_TRAP;
                endcase
            end
            // MEM_ADDR is only reachable with a load or store latched.
            ST_MEM_ADDR: state_next = (opcode_reg == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready) state_next = ST_MEM_WB;
            ST_MEM_WB:   state_next = ST_FETCH;
            ST_MEM_WR:   if (mem_ready) state_next = ST_FETCH;
            ST_EXEC_R:   state_next = ST_ALU_WB;
            ST_ALU_WB:   state_next = ST_FETCH;
            ST_BRANCH:   state_next = ST_FETCH;
            ST_TRAP:     state_next = ST_TRAP;
            default:     state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        retire_inc = 1'b0;
        case (state_reg)
            ST_MEM_WB, ST_ALU_WB, ST_BRANCH: retire_inc = 1'b1;
            ST_MEM_WR:                       retire_inc = mem_ready;
            ST_DECODE:                       retire_inc = (opcode == OP_NOP);
            default:                         retire_inc = 1'b0;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_ADD;
        pc_src     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_SUB;
                pc_src    = 1'b1;
                pc_write  = zero;
            end
            default: begin
            end
        endcase
    end

    retire_counter u_retire (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_inc),
        .count (retired)
    );

    assign illegal = illegal_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each driven cycle queues its
// expected state, strobe vector and retired count for the monitor.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    // {pc_write,ir_write,mem_read,mem_write,i_or_d,reg_write,mem_to_reg,
    //  alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src, illegal}
    localparam logic [13:0] SB_FETCH_RDY  = 14'b1110000_0_01_00_0_0;
    localparam logic [13:0] SB_FETCH_WAIT = 14'b0010000_0_01_00_0_0;
    localparam logic [13:0] SB_DECODE     = 14'b0000000_0_11_00_0_0;
    localparam logic [13:0] SB_MEM_ADDR   = 14'b0000000_1_11_00_0_0;
    localparam logic [13:0] SB_MEM_RD     = 14'b0010100_0_00_00_0_0;
    localparam logic [13:0] SB_MEM_WB     = 14'b0000011_0_00_00_0_0;
    localparam logic [13:0] SB_MEM_WR     = 14'b0001100_0_00_00_0_0;
    localparam logic [13:0] SB_EXEC_R     = 14'b0000000_1_00_10_0_0;
    localparam logic [13:0] SB_ALU_WB     = 14'b0000010_0_00_00_0_0;
    localparam logic [13:0] SB_BR_TAKEN   = 14'b1000000_1_00_01_1_0;
    localparam logic [13:0] SB_BR_NOT     = 14'b0000000_1_00_01_1_0;
    localparam logic [13:0] SB_TRAP       = 14'b0000000_0_00_00_0_1;
    localparam logic [6:0]  OP_BAD        = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_read, mem_write, i_or_d;
    logic        reg_write, mem_to_reg, alu_src_a, pc_src, illegal;
    logic [1:0]  alu_src_b, alu_op;
    logic [31:0] retired;
    logic [3:0]  state;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [13:0] sb;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .retired    (retired),
        .state      (state)
    );

    always #5 clk = ~clk;

    logic [13:0] act_sb;
    assign act_sb = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
                     mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal};

    task automatic check(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s actual=%h expected=%h", name, what, act, exp);
        end
    endtask

    // Monitor: one line per observed cycle, three comparisons each.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("t=%0t %s state=%0d strobes=%b retired=%h", $time, e.name,
                     state, act_sb, retired);
            check(e.name, "state",   {28'd0, state},  {28'd0, e.st});
            check(e.name, "strobes", {18'd0, act_sb}, {18'd0, e.sb});
            check(e.name, "retired", retired,         e.ret);
        end
    end

    task automatic step(input string name, input logic r, input logic [6:0] op,
                        input logic z, input logic mr, input logic [3:0] es,
                        input logic [13:0] eb, input logic [31:0] er);
        exp_t e;
        rst       = r;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        e.name = name;
        e.st   = es;
        e.sb   = eb;
        e.ret  = er;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = OP_NOP; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset0", 1, OP_NOP, 0, 0, ST_FETCH, SB_FETCH_WAIT, 0);
        step("reset1", 1, OP_NOP, 0, 1, ST_FETCH, SB_FETCH_RDY,  0);

        // R-type; garbage opcode outside DECODE must be ignored
        step("r_fetch",  0, OP_R,   0, 1, ST_FETCH,  SB_FETCH_RDY, 0);
        step("r_decode", 0, OP_R,   0, 1, ST_DECODE, SB_DECODE,    0);
        step("r_exec",   0, OP_BAD, 0, 1, ST_EXEC_R, SB_EXEC_R,    0);
        step("r_wb",     0, OP_BAD, 0, 1, ST_ALU_WB, SB_ALU_WB,    0);

        // load with three wait cycles in MEM_RD (8 cycles total)
        step("ld_fetch", 0, OP_BAD,  0, 1, ST_FETCH,    SB_FETCH_RDY, 1);
        step("ld_dec",   0, OP_LOAD, 0, 1, ST_DECODE,   SB_DECODE,    1);
        step("ld_addr",  0, OP_STORE,0, 1, ST_MEM_ADDR, SB_MEM_ADDR,  1);
        step("ld_rd0",   0, OP_STORE,0, 0, ST_MEM_RD,   SB_MEM_RD,    1);
        step("ld_rd1",   0, OP_STORE,0, 0, ST_MEM_RD,   SB_MEM_RD,    1);
        step("ld_rd2",   0, OP_STORE,0, 0, ST_MEM_RD,   SB_MEM_RD,    1);
        step("ld_rd3",   0, OP_STORE,0, 1, ST_MEM_RD,   SB_MEM_RD,    1);
        step("ld_wb",    0, OP_STORE,0, 1, ST_MEM_WB,   SB_MEM_WB,    1);

        // store, one wait cycle in FETCH first
        step("st_fwait", 0, OP_STORE,0, 0, ST_FETCH,    SB_FETCH_WAIT, 2);
        step("st_fetch", 0, OP_STORE,0, 1, ST_FETCH,    SB_FETCH_RDY,  2);
        step("st_dec",   0, OP_STORE,0, 1, ST_DECODE,   SB_DECODE,     2);
        step("st_addr",  0, OP_LOAD, 0, 1, ST_MEM_ADDR, SB_MEM_ADDR,   2);
        step("st_wr",    0, OP_LOAD, 0, 1, ST_MEM_WR,   SB_MEM_WR,     2);

        // branch taken then not taken
        step("bt_fetch", 0, OP_BRANCH, 0, 1, ST_FETCH,  SB_FETCH_RDY, 3);
        step("bt_dec",   0, OP_BRANCH, 0, 1, ST_DECODE, SB_DECODE,    3);
        step("bt_br",    0, OP_BRANCH, 1, 1, ST_BRANCH, SB_BR_TAKEN,  3);
        step("bn_fetch", 0, OP_BRANCH, 1, 1, ST_FETCH,  SB_FETCH_RDY, 4);
        step("bn_dec",   0, OP_BRANCH, 1, 1, ST_DECODE, SB_DECODE,    4);
        step("bn_br",    0, OP_BRANCH, 0, 1, ST_BRANCH, SB_BR_NOT,    4);

        // NOP: two cycles, retires
        step("nop_fetch",0, OP_NOP, 0, 1, ST_FETCH,  SB_FETCH_RDY, 5);
        step("nop_dec",  0, OP_NOP, 0, 1, ST_DECODE, SB_DECODE,    5);

        // illegal opcode -> sticky TRAP for 20 cycles, inputs toggling
        step("tr_fetch", 0, OP_BAD, 0, 1, ST_FETCH,  SB_FETCH_RDY, 6);
        step("tr_dec",   0, OP_BAD, 0, 1, ST_DECODE, SB_DECODE,    6);
        for (int i = 0; i < 20; i++) begin
            step("trap", 0, (i % 2 == 0) ? OP_NOP : OP_R, i[0], i[1],
                 ST_TRAP, SB_TRAP, 6);
        end
        step("tr_rst",   1, OP_NOP, 0, 0, ST_FETCH, SB_FETCH_WAIT, 0);

        // reset asserted mid-store: takes effect before the next edge
        step("sr_fetch", 0, OP_STORE, 0, 1, ST_FETCH,    SB_FETCH_RDY, 0);
        step("sr_dec",   0, OP_STORE, 0, 1, ST_DECODE,   SB_DECODE,    0);
        step("sr_addr",  0, OP_STORE, 0, 1, ST_MEM_ADDR, SB_MEM_ADDR,  0);
        step("sr_wr",    0, OP_STORE, 0, 0, ST_MEM_WR,   SB_MEM_WR,    0);
        step("sr_rst",   1, OP_STORE, 0, 1, ST_FETCH,    SB_FETCH_RDY, 0);
        step("sr_after", 0, OP_NOP,   0, 0, ST_FETCH,    SB_FETCH_WAIT,0);

        // wrap: preload counter, then one NOP
        force dut.u_retire.count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.u_retire.count_reg;
        step("wr_fwait", 0, OP_NOP, 0, 0, ST_FETCH,  SB_FETCH_WAIT, 32'hFFFF_FFFF);
        step("wr_fetch", 0, OP_NOP, 0, 1, ST_FETCH,  SB_FETCH_RDY,  32'hFFFF_FFFF);
        step("wr_dec",   0, OP_NOP, 0, 1, ST_DECODE, SB_DECODE,     32'hFFFF_FFFF);
        step("wr_done",  0, OP_NOP, 0, 0, ST_FETCH,  SB_FETCH_WAIT, 32'h0000_0000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
